instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control unit that sequences the shared 2-bit-opcode ALU and register file for the MIPS-lite core. Fetches 32-bit instructions over a request/acknowledge memory port, decodes R/I/J formats, drives ALU operation and operand select, and commits register writeback and PC updates. Sits between instruction memory and the datapath; the datapath holds no control state of its own.

## Interface
- `RESET_PC`, default 8'h00: PC loaded on reset and on every start.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin execution from `RESET_PC`; honoured only in IDLE or HALTED.
- `imem_req` out 1: fetch request, held until acknowledged.
- `imem_addr` out 8: word address of fetch (= `pc`).
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `rf_raddr_a` out 5: rs field.
- `rf_raddr_b` out 5: rt field.
- `rf_we` out 1: register write strobe, one cycle.
- `rf_waddr` out 5: destination register.
- `alu_op` out 2: `op_code` (OR/AND/ADD/SUB).
- `alu_b_sel` out 1: 0 = rt operand, 1 = `imm_ext`.
- `imm_ext` out 32: extended immediate.
- `alu_zero` in 1: ALU result == 0, sampled in EXEC.
- `pc` out 8: current program counter.
- `busy` out 1: high in FETCH, DECODE, EXEC, WB.
- `halted` out 1: high in HALTED.
- `illegal` out 1: sticky; set on undecodable instruction.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE: `start` -> FETCH, `pc`<=`RESET_PC`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`; on `imem_ack` latch IR, `pc`<=`pc`+1 (mod 256) -> DECODE.
- DECODE: drive `rf_raddr_a/b` from IR; -> EXEC. Read addresses stay stable through WB.
- EXEC: `alu_op`, `alu_b_sel`, `imm_ext` valid.
  - R-type (opcode 6'h00): funct 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR -> WB, dest rd. Other funct = illegal.
  - ADDI 6'h08 (sign-extend), ANDI 6'h0C / ORI 6'h0D (zero-extend) -> WB, dest rt.
  - BEQ 6'h04: `alu_op`=SUB, `alu_b_sel`=0; if `alu_zero`, `pc`<=`pc`+imm[7:0] (mod 256); -> FETCH.
  - J 6'h02: `pc`<=addr[7:0]; -> FETCH.
  - HALT 6'h3F: -> HALTED.
  - Anything else: `illegal`<=1 -> HALTED.
- WB: `rf_we`=1 for one cycle unless `rf_waddr`==0 (write suppressed); -> FETCH.
- HALTED: `start` clears `illegal`, `pc`<=`RESET_PC`, -> FETCH.
- `start` outside IDLE/HALTED is ignored.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, all other outputs 0.
- ALU instruction: 4 cycles + memory wait (FETCH≥1, DECODE, EXEC, WB). BEQ/J: 3 cycles + wait.
- `imem_req`/`imem_addr` held stable until the ack cycle; ack in the same cycle as req is legal (zero wait).
- `imem_ack` outside FETCH is ignored.
- Reset mid-fetch: `imem_req` low the cycle after reset is sampled; late ack discarded.
- Registered outputs; `alu_op`/`imm_ext` combinational from IR but only meaningful in EXEC.

## Configuration
- `SEQ_BRANCH_EN` defined: BEQ decoded as above.
- Undefined: opcode 6'h04 treated as illegal (`illegal`=1, HALTED); `alu_zero` unused.

## Structure
- Package `definitions`: add `seq_state` enum, opcode/funct localparams, and a packed `ctrl_t` struct (alu_op, b_sel, sign_ext, writes_rd, writes_rt, is_branch, is_jump, is_halt, illegal). Existing `op_code`, `Instruction`, `RType`/`IType`/`JType`, `ProgramCounter` used unchanged.
- Sub-module `seq_decode`: combinational `Instruction` -> `ctrl_t`; FSM, PC and IR in `instr_sequencer`.

## Test plan
- Reset then `start`, memory acks at once with ADD r3,r1,r2 (0x00221820) -> `alu_op`=ADD, `alu_b_sel`=0 in EXEC, `rf_we`=1 with `rf_waddr`=3 four cycles after FETCH, `pc`=1.
- ADDI r5,r0,-1 (0x2005FFFF) -> `imm_ext`=0xFFFFFFFF, `alu_b_sel`=1, `rf_waddr`=5; ORI r5,r0,0xFFFF -> `imm_ext`=0x0000FFFF.
- BEQ at `pc`=0xFE, imm=3, `alu_zero`=1 -> `pc`=0x02 (wrap); `alu_zero`=0 -> `pc`=0xFF; no `rf_we`.
- ADD with rd=0 -> `rf_we` stays 0 through WB; J addr 0x40 -> next `imem_addr`=0x40.
- `imem_ack` withheld 5 cycles -> `imem_req`/`imem_addr` stable throughout; `reset` on cycle 3 -> `imem_req`=0 next cycle, state IDLE.
- Opcode 6'h3E -> `illegal`=1, `halted`=1; `start` -> `illegal`=0, fetch from `RESET_PC`; without `SEQ_BRANCH_EN`, BEQ -> `illegal`=1.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared types, opcodes and decoded-control struct for the MIPS-lite sequencer
package definitions;

    typedef enum logic [1:0] {
        OR  = 2'b00,
        AND = 2'b01,
        ADD = 2'b10,
        SUB = 2'b11
    } op_code;

    typedef logic [31:0] Instruction;
    typedef logic [7:0]  ProgramCounter;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } RType;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } IType;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] addr;
    } JType;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } seq_state;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef struct packed {
        op_code alu_op;
        logic   b_sel;
        logic   sign_ext;
        logic   writes_rd;
        logic   writes_rt;
        logic   is_branch;
        logic   is_jump;
        logic   is_halt;
        logic   illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_sequencer_decode.sv
// rtl/instr_sequencer_decode.sv - combinational instruction decode; BEQ decoded only when SEQ_BRANCH_EN is defined
module seq_decode
    import definitions::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [19:0] unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = instr[25:6];

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_RTYPE: begin
                ctrl.writes_rd = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ADD;
                    FN_SUB:  ctrl.alu_op = SUB;
                    FN_AND:  ctrl.alu_op = AND;
                    FN_OR:   ctrl.alu_op = OR;
                    default: begin
                        ctrl.writes_rd = 1'b0;
                        ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                ctrl.alu_op    = ADD;
                ctrl.b_sel     = 1'b1;
                ctrl.sign_ext  = 1'b1;
                ctrl.writes_rt = 1'b1;
            end
            OPC_ANDI: begin
                ctrl.alu_op    = AND;
                ctrl.b_sel     = 1'b1;
                ctrl.writes_rt = 1'b1;
            end
            OPC_ORI: begin
                ctrl.alu_op    = OR;
                ctrl.b_sel     = 1'b1;
                ctrl.writes_rt = 1'b1;
            end
`ifdef SEQ_BRANCH_EN
            OPC_BEQ: begin
                ctrl.alu_op    = SUB;
                ctrl.is_branch = 1'b1;
                ctrl.sign_ext  = 1'b1;
            end
`else
            OPC_BEQ: ctrl.illegal = 1'b1;
`endif
            OPC_J:    ctrl.is_jump = 1'b1;
            OPC_HALT: ctrl.is_halt = 1'b1;
            default:  ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/writeback sequencer; BEQ support via SEQ_BRANCH_EN
module instr_sequencer
    import definitions::*;
#(
    parameter ProgramCounter RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr_a,
    output logic [4:0]  rf_raddr_b,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [1:0]  alu_op,
    output logic        alu_b_sel,
    output logic [31:0] imm_ext,
    input  logic        alu_zero,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    seq_state   state;
    Instruction ir;
    ctrl_t      ctrl;
    logic [4:0] dest;

    seq_decode u_decode (
        .instr (ir),
        .ctrl  (ctrl)
    );

    assign imem_addr = pc;
    assign alu_op    = ctrl.alu_op;
    assign alu_b_sel = ctrl.b_sel;
    assign imm_ext   = ctrl.sign_ext ? {{16{ir[15]}}, ir[15:0]} : {16'h0000, ir[15:0]};
    assign dest      = ctrl.writes_rd ? ir[15:11] : ir[20:16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_req   <= 1'b0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= RESET_PC;
                        illegal  <= 1'b0;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + 8'd1;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rf_raddr_a <= ir[25:21];
                    rf_raddr_b <= ir[20:16];
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (ctrl.illegal || ctrl.is_halt) begin
                        illegal <= illegal | ctrl.illegal;
                        halted  <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_HALTED;
                    end else if (ctrl.is_branch || ctrl.is_jump) begin
                        // pc already points past the branch, so the offset is relative to pc+1
                        if (ctrl.is_jump)
                            pc <= ir[7:0];
                        else if (alu_zero)
                            pc <= pc + ir[7:0];
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        rf_waddr <= dest;
                        rf_we    <= (dest != 5'd0);
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    rf_we    <= 1'b0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [1:0]  alu_op;
    logic        alu_b_sel;
    logic [31:0] imm_ext;
    logic        alu_zero = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        illegal;

    int total  = 0;
    int passed = 0;

    instr_sequencer #(.RESET_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .alu_op     (alu_op),
        .alu_b_sel  (alu_b_sel),
        .imm_ext    (imm_ext),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a pending fetch, acks it at once, and returns in the EXEC cycle.
    task automatic issue(input logic [31:0] instr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++; if (imem_req !== 1'b1) $display("FAIL issue_req_timeout got=%0d exp=1", imem_req); else passed++;
        imem_ack   = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack   = 1'b0;
        step();
    endtask

    task automatic do_reset_start();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (busy !== 1'b0)      $display("FAIL rst_busy got=%0d exp=0", busy); else passed++;
        total++; if (halted !== 1'b0)    $display("FAIL rst_halted got=%0d exp=0", halted); else passed++;
        total++; if (imem_req !== 1'b0)  $display("FAIL rst_req got=%0d exp=0", imem_req); else passed++;
        total++; if (pc !== 8'h00)       $display("FAIL rst_pc got=%h exp=00", pc); else passed++;
        total++; if (rf_we !== 1'b0)     $display("FAIL rst_we got=%0d exp=0", rf_we); else passed++;
        total++; if (illegal !== 1'b0)   $display("FAIL rst_illegal got=%0d exp=0", illegal); else passed++;
        total++; if (imm_ext !== 32'h0)  $display("FAIL rst_imm got=%h exp=0", imm_ext); else passed++;
    endtask

    task automatic test_alu_add();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (imem_addr !== 8'h00) $display("FAIL add_addr got=%h exp=00", imem_addr); else passed++;
        issue(32'h00221820);
        total++; if (alu_op !== 2'd2)     $display("FAIL add_aluop got=%0d exp=2", alu_op); else passed++;
        total++; if (alu_b_sel !== 1'b0)  $display("FAIL add_bsel got=%0d exp=0", alu_b_sel); else passed++;
        total++; if (rf_raddr_a !== 5'd1) $display("FAIL add_ra got=%0d exp=1", rf_raddr_a); else passed++;
        total++; if (rf_raddr_b !== 5'd2) $display("FAIL add_rb got=%0d exp=2", rf_raddr_b); else passed++;
        step();
        total++; if (rf_we !== 1'b1)      $display("FAIL add_we got=%0d exp=1", rf_we); else passed++;
        total++; if (rf_waddr !== 5'd3)   $display("FAIL add_waddr got=%0d exp=3", rf_waddr); else passed++;
        total++; if (pc !== 8'h01)        $display("FAIL add_pc got=%h exp=01", pc); else passed++;
        step();
        total++; if (rf_we !== 1'b0)      $display("FAIL add_we_pulse got=%0d exp=0", rf_we); else passed++;
        total++; if (imem_addr !== 8'h01) $display("FAIL add_next_addr got=%h exp=01", imem_addr); else passed++;
    endtask

    task automatic test_immediates();
        issue(32'h2005FFFF);
        total++; if (imm_ext !== 32'hFFFFFFFF) $display("FAIL addi_imm got=%h exp=ffffffff", imm_ext); else passed++;
        total++; if (alu_b_sel !== 1'b1)       $display("FAIL addi_bsel got=%0d exp=1", alu_b_sel); else passed++;
        step();
        total++; if (rf_waddr !== 5'd5)        $display("FAIL addi_waddr got=%0d exp=5", rf_waddr); else passed++;
        total++; if (rf_we !== 1'b1)           $display("FAIL addi_we got=%0d exp=1", rf_we); else passed++;
        step();
        issue(32'h3405FFFF);
        total++; if (imm_ext !== 32'h0000FFFF) $display("FAIL ori_imm got=%h exp=0000ffff", imm_ext); else passed++;
        total++; if (alu_op !== 2'd0)          $display("FAIL ori_aluop got=%0d exp=0", alu_op); else passed++;
        step();
        step();
    endtask

    task automatic test_zero_rd_and_jump();
        issue(32'h00220020);
        step();
        total++; if (rf_we !== 1'b0)      $display("FAIL rd0_we got=%0d exp=0", rf_we); else passed++;
        step();
        total++; if (pc !== 8'h04)        $display("FAIL rd0_pc got=%h exp=04", pc); else passed++;
        issue(32'h08000040);
        step();
        total++; if (imem_addr !== 8'h40) $display("FAIL j_addr got=%h exp=40", imem_addr); else passed++;
        total++; if (imem_req !== 1'b1)   $display("FAIL j_req got=%0d exp=1", imem_req); else passed++;
    endtask

    task automatic test_branch();
`ifdef SEQ_BRANCH_EN
        issue(32'h080000FE);
        step();
        issue(32'h10220003);
        total++; if (alu_op !== 2'd3)     $display("FAIL beq_aluop got=%0d exp=3", alu_op); else passed++;
        total++; if (alu_b_sel !== 1'b0)  $display("FAIL beq_bsel got=%0d exp=0", alu_b_sel); else passed++;
        alu_zero = 1'b1;
        step();
        alu_zero = 1'b0;
        total++; if (pc !== 8'h02)        $display("FAIL beq_taken_pc got=%h exp=02", pc); else passed++;
        total++; if (rf_we !== 1'b0)      $display("FAIL beq_we got=%0d exp=0", rf_we); else passed++;
        issue(32'h080000FE);
        step();
        issue(32'h10220003);
        step();
        total++; if (pc !== 8'hFF)        $display("FAIL beq_nt_pc got=%h exp=ff", pc); else passed++;
        total++; if (imem_req !== 1'b1)   $display("FAIL beq_nt_req got=%0d exp=1", imem_req); else passed++;
`else
        issue(32'h10220003);
        step();
        total++; if (illegal !== 1'b1)    $display("FAIL beq_illegal got=%0d exp=1", illegal); else passed++;
        total++; if (halted !== 1'b1)     $display("FAIL beq_halted got=%0d exp=1", halted); else passed++;
`endif
    endtask

    task automatic test_wait_and_reset();
        do_reset_start();
        for (int i = 0; i < 5; i++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
                $display("FAIL wait_hold[%0d] got=%0d/%h exp=1/00", i, imem_req, imem_addr); else passed++;
            step();
        end
        do_reset_start();
        step();
        step();
        reset    = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h00221820;
        step();
        reset = 1'b0;
        total++; if (imem_req !== 1'b0)   $display("FAIL midrst_req got=%0d exp=0", imem_req); else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL midrst_busy got=%0d exp=0", busy); else passed++;
        step();
        imem_ack = 1'b0;
        total++; if (pc !== 8'h00 || busy !== 1'b0)
            $display("FAIL idle_ack_ignored got=%h/%0d exp=00/0", pc, busy); else passed++;
    endtask

    task automatic test_illegal();
        do_reset_start();
        issue(32'hF8000000);
        step();
        total++; if (illegal !== 1'b1)    $display("FAIL ill_flag got=%0d exp=1", illegal); else passed++;
        total++; if (halted !== 1'b1)     $display("FAIL ill_halted got=%0d exp=1", halted); else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL ill_busy got=%0d exp=0", busy); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (illegal !== 1'b0)    $display("FAIL restart_illegal got=%0d exp=0", illegal); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
            $display("FAIL restart_fetch got=%0d/%h exp=1/00", imem_req, imem_addr); else passed++;
        issue(32'h00220021);
        step();
        total++; if (illegal !== 1'b1)    $display("FAIL bad_funct got=%0d exp=1", illegal); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        issue(32'hFC000000);
        step();
        total++; if (halted !== 1'b1 || illegal !== 1'b0)
            $display("FAIL halt_instr got=%0d/%0d exp=1/0", halted, illegal); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_immediates();
        test_zero_rd_and_jump();
        test_branch();
        test_wait_and_reset();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
